// File: rtl/pixel_rmw_writer_if.sv
// Command and memory-port bundle for pixel_rmw_writer.
// master = address generator / memory side, slave = the writer itself.
interface pixel_rmw_writer_if;
   localparam int unsigned CMD_W  = 40;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 16;

   logic              pixel_cmd_rdy;
   logic [CMD_W-1:0]  pixel_cmd;
   logic              draw_busy;
   logic              mem_req;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_ack;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rd_data;

   modport master (
      output pixel_cmd_rdy, pixel_cmd, mem_ack, mem_rd_valid, mem_rd_data,
      input  draw_busy, mem_req, mem_wr, mem_addr, mem_wr_data
   );

   modport slave (
      input  pixel_cmd_rdy, pixel_cmd, mem_ack, mem_rd_valid, mem_rd_data,
      output draw_busy, mem_req, mem_wr, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/pixel_rmw_writer.sv
// Single-pixel read-modify-write engine for 16-bit display memory words.
// Handles 1/2/4/8/16 bpp, transparency masks, copy/paste buffer and collision counting.
module pixel_rmw_writer #(
   parameter int unsigned COLL_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pixel_rmw_writer_if.slave    bus,
   output logic [31:0]          argb,
   output logic [COLL_W-1:0]    collision_cnt,
   output logic                 cmd_err
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 20;

   localparam logic [3:0] CMD_PXWRI       = 4'd1;
   localparam logic [3:0] CMD_PXWRI_M     = 4'd2;
   localparam logic [3:0] CMD_PXPASTE     = 4'd3;
   localparam logic [3:0] CMD_PXPASTE_M   = 4'd4;
   localparam logic [3:0] CMD_PXCOPY      = 4'd6;
   localparam logic [3:0] CMD_SETARGB     = 4'd7;
   localparam logic [3:0] CMD_RST_PXWRI_M = 4'd10;
   localparam logic [3:0] CMD_RST_PASTE_M = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_RWAIT  = 3'd2,
      ST_MODIFY = 3'd3,
      ST_WRITE  = 3'd4
   } state_t;

   state_t state, state_nx;

   logic               draw_busy_nx, mem_req_nx, mem_wr_nx;

   // Latched command fields for the command in flight
   logic [3:0]         op_q;
   logic [7:0]         colour_q;
   logic [3:0]         width_q;
   logic [3:0]         target_q;
   logic [DATA_W-1:0]  rd_word;
   logic [DATA_W-1:0]  paste_buf;
   logic [7:0]         wr_mask;
   logic [7:0]         paste_mask;

   // Accept-cycle decode
   logic               accept_c;
   logic [3:0]         acc_op;
   logic [7:0]         acc_colour;
   logic [3:0]         acc_width;
   logic               acc_width_ok;
   logic               acc_is_mem;
   logic               acc_skip;
   logic               acc_go;
   logic               acc_wr16;
   logic               acc_err;
   logic [DATA_W-1:0]  acc_data;

   // Modify-cycle datapath
   logic [3:0]         lsb;
   logic [DATA_W-1:0]  fmask;
   logic [DATA_W-1:0]  src_data;
   logic [DATA_W-1:0]  merged;
   logic [DATA_W-1:0]  extracted;
   logic               is_paste_q;

   function automatic logic [DATA_W-1:0] width_mask(input logic [3:0] w);
      case (w)
         4'd0:    width_mask = 16'h0001;
         4'd1:    width_mask = 16'h0003;
         4'd3:    width_mask = 16'h000F;
         4'd7:    width_mask = 16'h00FF;
         4'd15:   width_mask = 16'hFFFF;
         default: width_mask = 16'h0000;
      endcase
   endfunction

   function automatic logic width_valid(input logic [3:0] w);
      width_valid = (w == 4'd0) || (w == 4'd1) || (w == 4'd3) || (w == 4'd7) || (w == 4'd15);
   endfunction

   // Decode of the command presented while idle
   always_comb begin
      acc_op       = bus.pixel_cmd[39:36];
      acc_colour   = bus.pixel_cmd[35:28];
      acc_width    = bus.pixel_cmd[27:24];
      accept_c     = bus.pixel_cmd_rdy && (state == ST_IDLE);
      acc_width_ok = width_valid(acc_width);
      acc_is_mem   = (acc_op == CMD_PXWRI) || (acc_op == CMD_PXWRI_M) ||
                     (acc_op == CMD_PXPASTE) || (acc_op == CMD_PXPASTE_M) ||
                     (acc_op == CMD_PXCOPY);
      acc_skip     = ((acc_op == CMD_PXWRI_M) && (acc_colour == wr_mask)) ||
                     ((acc_op == CMD_PXPASTE_M) && (paste_buf[7:0] == paste_mask));
      acc_go       = accept_c && acc_is_mem && acc_width_ok && !acc_skip;
      acc_err      = accept_c && acc_is_mem && !acc_width_ok;
      acc_wr16     = acc_go && (acc_op != CMD_PXCOPY) && (acc_width == 4'd15);
      if ((acc_op == CMD_PXPASTE) || (acc_op == CMD_PXPASTE_M)) begin
         acc_data = paste_buf;
      end else begin
         acc_data = {argb[15:8], acc_colour};
      end
   end

   // Field merge / extract on the captured read word
   always_comb begin
      is_paste_q = (op_q == CMD_PXPASTE) || (op_q == CMD_PXPASTE_M);
      lsb        = target_q & ~width_q;
      fmask      = width_mask(width_q);
      src_data   = is_paste_q ? paste_buf : {8'h00, colour_q};
      merged     = (rd_word & ~(fmask << lsb)) | ((src_data & fmask) << lsb);
      extracted  = (rd_word >> lsb) & fmask;
   end

   // State register and registered handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         bus.draw_busy <= 1'b0;
         bus.mem_req   <= 1'b0;
         bus.mem_wr    <= 1'b0;
      end else begin
         state         <= state_nx;
         bus.draw_busy <= draw_busy_nx;
         bus.mem_req   <= mem_req_nx;
         bus.mem_wr    <= mem_wr_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (acc_go) begin
               state_nx = acc_wr16 ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            if (bus.mem_ack) state_nx = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (bus.mem_rd_valid) state_nx = ST_MODIFY;
         end
         ST_MODIFY: begin
            state_nx = (op_q == CMD_PXCOPY) ? ST_IDLE : ST_WRITE;
         end
         ST_WRITE: begin
            if (bus.mem_ack) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Output decode of the upcoming state, registered alongside it
   always_comb begin
      draw_busy_nx = 1'b0;
      mem_req_nx   = 1'b0;
      mem_wr_nx    = 1'b0;
      case (state_nx)
         ST_READ: begin
            draw_busy_nx = 1'b1;
            mem_req_nx   = 1'b1;
         end
         ST_RWAIT, ST_MODIFY: begin
            draw_busy_nx = 1'b1;
         end
         ST_WRITE: begin
            draw_busy_nx = 1'b1;
            mem_req_nx   = 1'b1;
            mem_wr_nx    = 1'b1;
         end
         default: ;
      endcase
   end

   // Command latch, configuration registers and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q            <= 4'd0;
         colour_q        <= 8'd0;
         width_q         <= 4'd0;
         target_q        <= 4'd0;
         rd_word         <= '0;
         paste_buf       <= '0;
         wr_mask         <= 8'd0;
         paste_mask      <= 8'd0;
         argb            <= 32'd0;
         collision_cnt   <= '0;
         cmd_err         <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_wr_data <= '0;
      end else begin
         if (accept_c) begin
            case (acc_op)
               CMD_SETARGB:     argb       <= bus.pixel_cmd[31:0];
               CMD_RST_PXWRI_M: wr_mask    <= bus.pixel_cmd[7:0];
               CMD_RST_PASTE_M: begin
                  paste_mask    <= bus.pixel_cmd[7:0];
                  collision_cnt <= '0;
               end
               default: ;
            endcase
            if (acc_err) cmd_err <= 1'b1;
         end

         if (acc_go) begin
            op_q         <= acc_op;
            colour_q     <= acc_colour;
            width_q      <= acc_width;
            target_q     <= bus.pixel_cmd[23:20];
            bus.mem_addr <= {bus.pixel_cmd[ADDR_W-1:1], 1'b0};
            if (acc_wr16) bus.mem_wr_data <= acc_data;
         end

         if ((state == ST_RWAIT) && bus.mem_rd_valid) begin
            rd_word <= bus.mem_rd_data;
         end

         if (state == ST_MODIFY) begin
            if (op_q == CMD_PXCOPY) begin
               paste_buf <= extracted;
               if ((extracted[7:0] != colour_q) && (collision_cnt != {COLL_W{1'b1}})) begin
                  collision_cnt <= collision_cnt + COLL_W'(1);
               end
            end else begin
               bus.mem_wr_data <= merged;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_rmw_writer.sv
// Directed bench for pixel_rmw_writer with a single-word memory responder.
// A narrow collision counter is used so saturation is reachable quickly.
module tb_pixel_rmw_writer;
   localparam int unsigned COLL_W = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [31:0]       argb;
   logic [COLL_W-1:0] collision_cnt;
   logic              cmd_err;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          ack_delay = 0;
   int          rd_delay  = 0;
   int          wait_cnt  = 0;
   int          rd_pending = 0;
   int          wr_count = 0;
   int          rd_count = 0;
   logic [15:0] mem_word = 16'h0000;
   logic [15:0] last_wr_data = 16'h0000;

   pixel_rmw_writer_if bus ();

   pixel_rmw_writer #(.COLL_W(COLL_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .argb          (argb),
      .collision_cnt (collision_cnt),
      .cmd_err       (cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [39:0] mk(input logic [3:0] op, input logic [7:0] col,
                                      input logic [3:0] w, input logic [3:0] t,
                                      input logic [19:0] a);
      return {op, col, w, t, a};
   endfunction

   task automatic send(input logic [39:0] c);
      @(negedge clk);
      bus.pixel_cmd_rdy = 1'b1;
      bus.pixel_cmd     = c;
      @(posedge clk);
      #1 bus.pixel_cmd_rdy = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.draw_busy && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check(tag, 32'd0, 32'd1);
   endtask

   // Memory responder: ack after ack_delay cycles, read data rd_delay cycles after ack
   initial begin
      bus.mem_ack      = 1'b0;
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = 16'h0000;
      forever begin
         @(negedge clk);
         bus.mem_ack      = 1'b0;
         bus.mem_rd_valid = 1'b0;
         if (rd_pending > 0) begin
            rd_pending--;
            if (rd_pending == 0) begin
               bus.mem_rd_valid = 1'b1;
               bus.mem_rd_data  = mem_word;
            end
         end
         if (bus.mem_req && !reset) begin
            if (wait_cnt < ack_delay) begin
               wait_cnt++;
            end else begin
               wait_cnt    = 0;
               bus.mem_ack = 1'b1;
               if (bus.mem_wr) begin
                  wr_count++;
                  last_wr_data = bus.mem_wr_data;
               end else begin
                  rd_count++;
                  rd_pending = rd_delay + 1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int snap;
      logic seen_req;
      reset             = 1'b1;
      bus.pixel_cmd_rdy = 1'b0;
      bus.pixel_cmd     = 40'd0;
      repeat (3) @(negedge clk);
      check("rst_bus", {bus.draw_busy, bus.mem_req, bus.mem_wr}, 3'b000);
      check("rst_addr_data", {bus.mem_addr, bus.mem_wr_data}, 36'd0);
      check("rst_regs", {argb[7:0], collision_cnt, cmd_err}, 11'd0);
      reset = 1'b0;

      // 4bpp RMW, zero-wait memory
      mem_word = 16'h1234;
      send(mk(4'd1, 8'h0A, 4'd3, 4'd6, 20'h00100));
      @(negedge clk);
      check("rmw_t1_req", {bus.draw_busy, bus.mem_req, bus.mem_wr}, 3'b110);
      check("rmw_t1_addr", bus.mem_addr, 20'h00100);
      @(negedge clk);
      check("rmw_t2", {bus.draw_busy, bus.mem_req}, 2'b10);
      @(negedge clk);
      check("rmw_t3", {bus.draw_busy, bus.mem_req}, 2'b10);
      @(negedge clk);
      check("rmw_t4_wr", {bus.draw_busy, bus.mem_req, bus.mem_wr}, 3'b111);
      check("rmw_t4_data", bus.mem_wr_data, 16'h12A4);
      @(negedge clk);
      check("rmw_t5_idle", {bus.draw_busy, bus.mem_req}, 2'b00);

      // Transparency: masked colour skipped, other colour written
      snap = rd_count + wr_count;
      send(mk(4'hA, 8'h00, 4'd0, 4'd0, 20'h00005));
      send(mk(4'd2, 8'h05, 4'd3, 4'd0, 20'h00200));
      @(negedge clk);
      check("mask_skip_bus", {bus.draw_busy, bus.mem_req}, 2'b00);
      @(negedge clk);
      check("mask_skip_nomem", rd_count + wr_count, snap);
      mem_word = 16'hFFFF;
      send(mk(4'd2, 8'h06, 4'd3, 4'd4, 20'h00201));
      @(negedge clk);
      check("mask_pass_req", {bus.mem_req, bus.mem_wr, bus.mem_addr}, {2'b10, 20'h00200});
      wait_idle("mask_pass_timeout");
      check("mask_pass_data", last_wr_data, 16'hFF6F);

      // Copy/paste at 8bpp
      mem_word = 16'hBEEF;
      send(mk(4'd6, 8'h00, 4'd7, 4'd8, 20'h00300));
      @(negedge clk);
      check("copy_t1_rd", {bus.mem_req, bus.mem_wr}, 2'b10);
      @(negedge clk);
      @(negedge clk);
      check("copy_t3", {bus.draw_busy, collision_cnt}, {1'b1, 2'd0});
      @(negedge clk);
      check("copy_t4", {bus.draw_busy, collision_cnt}, {1'b0, 2'd1});
      mem_word = 16'h0000;
      send(mk(4'd3, 8'h00, 4'd7, 4'd0, 20'h00302));
      wait_idle("paste_timeout");
      check("paste_data", last_wr_data, 16'h00BE);
      send(mk(4'hB, 8'h00, 4'd0, 4'd0, 20'h000BE));
      @(negedge clk);
      check("paste_m_clr_coll", collision_cnt, 2'd0);
      snap = wr_count;
      send(mk(4'd4, 8'h00, 4'd7, 4'd0, 20'h00302));
      @(negedge clk);
      check("paste_m_skip", {bus.draw_busy, bus.mem_req}, 2'b00);
      check("paste_m_nowr", wr_count, snap);

      // Collision counter: match does not count, mismatches saturate
      mem_word = 16'hBEEF;
      send(mk(4'd6, 8'hBE, 4'd7, 4'd8, 20'h00300));
      wait_idle("copy_match_timeout");
      check("coll_match", collision_cnt, 2'd0);
      for (int i = 0; i < 4; i++) begin
         send(mk(4'd6, 8'h00, 4'd7, 4'd8, 20'h00300));
         wait_idle("copy_sat_timeout");
      end
      check("coll_sat", collision_cnt, 2'd3);

      // 16bpp direct write using ARGB high byte
      send({4'h7, 4'h0, 32'h0000_7700});
      @(negedge clk);
      check("setargb", argb, 32'h0000_7700);
      snap = rd_count;
      send(mk(4'd1, 8'h11, 4'd15, 4'd0, 20'h00400));
      @(negedge clk);
      check("w16_t1", {bus.draw_busy, bus.mem_req, bus.mem_wr}, 3'b111);
      check("w16_data", bus.mem_wr_data, 16'h7711);
      @(negedge clk);
      check("w16_t2_idle", {bus.draw_busy, bus.mem_req}, 2'b00);
      check("w16_noread", rd_count, snap);

      // Back-pressure: ack delayed 5 cycles
      ack_delay = 5;
      mem_word  = 16'h1234;
      send(mk(4'd1, 8'h0A, 4'd3, 4'd6, 20'h00500));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {bus.draw_busy, bus.mem_req, bus.mem_wr, bus.mem_addr},
               {3'b110, 20'h00500});
      end
      wait_idle("bp_timeout");
      check("bp_data", last_wr_data, 16'h12A4);
      ack_delay = 0;

      // Unsupported width code
      snap = rd_count + wr_count;
      send(mk(4'd1, 8'h0A, 4'd2, 4'd6, 20'h00600));
      @(negedge clk);
      check("werr_t1", {bus.draw_busy, bus.mem_req, cmd_err}, 3'b001);
      repeat (3) @(negedge clk);
      check("werr_sticky", {cmd_err, 32'(rd_count + wr_count)}, {1'b1, 32'(snap)});

      // Reset while waiting for read data
      rd_delay = 3;
      snap     = wr_count;
      send(mk(4'd1, 8'h0A, 4'd3, 4'd6, 20'h00700));
      @(negedge clk);
      @(negedge clk);
      check("rst_rwait_pre", {bus.draw_busy, bus.mem_req}, 2'b10);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_bus", {bus.draw_busy, bus.mem_req, bus.mem_wr}, 3'b000);
      check("rst_mid_regs", {argb, cmd_err, collision_cnt}, 35'd0);
      reset    = 1'b0;
      seen_req = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_req = seen_req | bus.mem_req | bus.draw_busy;
      end
      check("rst_late_valid", {seen_req, 32'(wr_count)}, {1'b0, 32'(snap)});
      rd_delay = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
